jtframe_dial_acc: RTL and testbench

- Parametrised N-channel rotary-dial/mouse position accumulator for Z80 cabinet I/O.
- Successor to the single-purpose per-player dial multiplexing in the main CPU glue. Adds any channel count, configurable counter width, sensitivity scaling, wrap or saturate modes, tear-free snapshot latching, and movement/direction flags.
- Sits between the framework mouse decoder and the main CPU input-port read mux.

---
 rtl/jtframe_dial_acc.sv | 75 +++++++
 tb/tb_jtframe_dial_acc.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_dial_acc.sv
// N-channel signed dial/mouse position accumulator with sensitivity shift,
// wrap/saturate modes, snapshot hold registers and a registered read mux.
module jtframe_dial_acc #(
    parameter int CH  = 2,
    parameter int DW  = 8,
    parameter int CW  = 8,
    parameter int SH  = 0,
    parameter int SAT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dx_stb,
    input  logic [CH*DW-1:0] dx,
    input  logic             snap,
    input  logic             clr,
    input  logic [CH-1:0]    clr_mask,
    input  logic [2:0]       sel,
    output logic [CW-1:0]    dout,
    output logic [CH-1:0]    moved,
    output logic [CH-1:0]    dir
);
    localparam int AW = CW + SH;
    localparam int SW = ((DW > AW) ? DW : AW) + 1;

    logic [AW-1:0] r_acc  [CH];
    logic [CW-1:0] r_hold [CH];
    logic [CW-1:0] w_rd;

    // Sum at full width so neither wide deltas nor the carry are lost before wrap/clamp.
    function automatic logic [AW-1:0] f_add(input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [SW-1:0] s;
        logic [AW-1:0] r;
        s = {{(SW-AW){a[AW-1]}}, a} + {{(SW-DW){d[DW-1]}}, d};
        r = s[AW-1:0];
        if (SAT != 0 && !((&s[SW-1:AW-1]) || !(|s[SW-1:AW-1]))) begin
            r         = {AW{~s[SW-1]}};
            r[AW-1]   = s[SW-1];
        end
        return r;
    endfunction

    always_comb begin
        w_rd = '1;
        for (int i = 0; i < CH; i++)
            if (sel == 3'(i)) w_rd = r_hold[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                r_acc[i]  <= '0;
                r_hold[i] <= '0;
            end
            moved <= '0;
            dir   <= '0;
            dout  <= '0;
        end else begin
            dout <= w_rd;
            for (int i = 0; i < CH; i++) begin
                if (snap) r_hold[i] <= r_acc[i][AW-1:SH];
                if (clr && clr_mask[i])
                    r_acc[i] <= '0;
                else if (dx_stb)
                    r_acc[i] <= f_add(r_acc[i], dx[i*DW +: DW]);
                // A fresh non-zero delta beats the snapshot clear of moved.
                if (dx_stb && dx[i*DW +: DW] != '0) begin
                    moved[i] <= 1'b1;
                    dir[i]   <= dx[i*DW + DW - 1];
                end else if (snap) begin
                    moved[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_jtframe_dial_acc.sv
// Drives four differently-parameterised accumulators with shared stimulus and
// compares them against an integer-arithmetic model of the dial behaviour.
module tb_jtframe_dial_acc;
    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             dx_stb = 1'b0;
    logic signed [7:0] dx0 = '0, dx1 = '0;
    logic             snap = 1'b0, clr = 1'b0;
    logic [1:0]       clr_mask = '0;
    logic [2:0]       sel = '0;

    logic [7:0] dout0, dout1, dout2;
    logic [3:0] dout3;
    logic [1:0] mv [4];
    logic [1:0] dr [4];
    logic [7:0] g_dout [4];

    int nvec = 0, nerr = 0;

    localparam int P_CW  [4] = '{8, 8, 8, 4};
    localparam int P_SH  [4] = '{0, 0, 2, 1};
    localparam int P_SAT [4] = '{0, 1, 0, 1};

    always #5 clk = ~clk;

    jtframe_dial_acc #(.CH(2), .DW(8), .CW(8), .SH(0), .SAT(0)) u0 (
        .clk(clk), .rst(rst), .dx_stb(dx_stb), .dx({dx1, dx0}), .snap(snap), .clr(clr),
        .clr_mask(clr_mask), .sel(sel), .dout(dout0), .moved(mv[0]), .dir(dr[0]));
    jtframe_dial_acc #(.CH(2), .DW(8), .CW(8), .SH(0), .SAT(1)) u1 (
        .clk(clk), .rst(rst), .dx_stb(dx_stb), .dx({dx1, dx0}), .snap(snap), .clr(clr),
        .clr_mask(clr_mask), .sel(sel), .dout(dout1), .moved(mv[1]), .dir(dr[1]));
    jtframe_dial_acc #(.CH(2), .DW(8), .CW(8), .SH(2), .SAT(0)) u2 (
        .clk(clk), .rst(rst), .dx_stb(dx_stb), .dx({dx1, dx0}), .snap(snap), .clr(clr),
        .clr_mask(clr_mask), .sel(sel), .dout(dout2), .moved(mv[2]), .dir(dr[2]));
    jtframe_dial_acc #(.CH(2), .DW(8), .CW(4), .SH(1), .SAT(1)) u3 (
        .clk(clk), .rst(rst), .dx_stb(dx_stb), .dx({dx1, dx0}), .snap(snap), .clr(clr),
        .clr_mask(clr_mask), .sel(sel), .dout(dout3), .moved(mv[3]), .dir(dr[3]));

    assign g_dout[0] = dout0;
    assign g_dout[1] = dout1;
    assign g_dout[2] = dout2;
    assign g_dout[3] = {4'h0, dout3};

    // Reference state: positions as plain signed integers
    int m_acc  [4][2];
    int m_hold [4][2];
    int m_dout [4];
    bit m_moved [2];
    bit m_dir   [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int step_acc(input int k, input int a, input int d);
        int aw, v, lo, hi;
        aw = P_CW[k] + P_SH[k];
        lo = -(1 << (aw - 1));
        hi = (1 << (aw - 1)) - 1;
        v  = a + d;
        if (P_SAT[k] != 0) begin
            if (v > hi) v = hi;
            if (v < lo) v = lo;
        end else begin
            v = v & ((1 << aw) - 1);
            if (v > hi) v = v - (1 << aw);
        end
        return v;
    endfunction

    function automatic int visible(input int k, input int a);
        return (a >>> P_SH[k]) & ((1 << P_CW[k]) - 1);
    endfunction

    task automatic model();
        int d [2];
        d[0] = dx0;
        d[1] = dx1;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_dout[k] = 0;
                for (int i = 0; i < 2; i++) begin
                    m_acc[k][i] = 0;
                    m_hold[k][i] = 0;
                end
            end
            for (int i = 0; i < 2; i++) begin
                m_moved[i] = 0;
                m_dir[i] = 0;
            end
            return;
        end
        for (int k = 0; k < 4; k++) begin
            m_dout[k] = (sel < 2) ? m_hold[k][sel] : ((1 << P_CW[k]) - 1);
            for (int i = 0; i < 2; i++) begin
                if (snap) m_hold[k][i] = visible(k, m_acc[k][i]);
                if (clr && clr_mask[i]) m_acc[k][i] = 0;
                else if (dx_stb) m_acc[k][i] = step_acc(k, m_acc[k][i], d[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (dx_stb && d[i] != 0) begin
                m_moved[i] = 1;
                m_dir[i] = (d[i] < 0);
            end else if (snap) begin
                m_moved[i] = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model();
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("dout%0d", k), 32'(g_dout[k]), 32'(m_dout[k]));
            chk($sformatf("moved%0d", k), 32'(mv[k]), 32'({m_moved[1], m_moved[0]}));
            chk($sformatf("dir%0d", k), 32'(dr[k]), 32'({m_dir[1], m_dir[0]}));
        end
    endtask

    task automatic drv(input bit stb, input int d0, input int d1, input bit sn,
                       input bit cl, input bit [1:0] m);
        dx_stb = stb;
        dx0 = 8'(d0);
        dx1 = 8'(d1);
        snap = sn;
        clr = cl;
        clr_mask = m;
        tick();
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 2'b00);
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        chk("rst_dout", 32'(dout0), 32'h0);
        rst = 1'b0;

        // Three +5 steps on ch0
        sel = 3'd0;
        repeat (3) drv(1, 5, 0, 0, 0, 2'b00);
        chk("acc15_moved", 32'(mv[0]), 32'h1);
        drv(0, 0, 0, 1, 0, 2'b00);
        idle();
        chk("acc15_dout", 32'(dout0), 32'h0F);

        // Wrap vs saturate
        drv(0, 0, 0, 0, 1, 2'b11);
        drv(1, -2, 0, 0, 0, 2'b00);
        drv(1, 3, 0, 0, 0, 2'b00);
        drv(0, 0, 0, 1, 0, 2'b00);
        idle();
        chk("wrap_fe", 32'(dout0), 32'h01);
        drv(0, 0, 0, 0, 1, 2'b11);
        drv(1, 126, 0, 0, 0, 2'b00);
        drv(1, 3, 0, 0, 0, 2'b00);
        drv(0, 0, 0, 1, 0, 2'b00);
        idle();
        chk("sat_hi", 32'(dout1), 32'h7F);
        chk("wrap_hi", 32'(dout0), 32'h81);
        drv(0, 0, 0, 0, 1, 2'b11);
        drv(1, -127, 0, 0, 0, 2'b00);
        drv(1, -4, 0, 0, 0, 2'b00);
        drv(0, 0, 0, 1, 0, 2'b00);
        idle();
        chk("sat_lo", 32'(dout1), 32'h80);
        chk("wrap_lo", 32'(dout0), 32'h7D);

        // Sensitivity shift of 2 on ch1
        sel = 3'd1;
        drv(0, 0, 0, 0, 1, 2'b11);
        repeat (4) drv(1, 0, 1, 0, 0, 2'b00);
        drv(0, 0, 0, 1, 0, 2'b00);
        idle();
        chk("sh2_four", 32'(dout2), 32'h1);
        drv(0, 0, 0, 0, 1, 2'b11);
        repeat (3) drv(1, 0, 1, 0, 0, 2'b00);
        drv(0, 0, 0, 1, 0, 2'b00);
        idle();
        chk("sh2_three", 32'(dout2), 32'h0);

        // Clear and delta on the same edge
        sel = 3'd0;
        drv(0, 0, 0, 1, 1, 2'b11);
        drv(1, 9, 0, 0, 0, 2'b00);
        drv(0, 0, 0, 1, 0, 2'b00);
        drv(1, 7, 0, 0, 1, 2'b01);
        chk("clrdx_moved", 32'(mv[0][0]), 32'h1);
        drv(0, 0, 0, 1, 0, 2'b00);
        idle();
        chk("clrdx_dout", 32'(dout0), 32'h0);

        // Snapshot and delta on the same edge
        drv(0, 0, 0, 0, 1, 2'b11);
        drv(1, 4, 0, 0, 0, 2'b00);
        drv(1, 2, 0, 1, 0, 2'b00);
        idle();
        chk("snapdx_pre", 32'(dout0), 32'h4);
        drv(0, 0, 0, 1, 0, 2'b00);
        idle();
        chk("snapdx_post", 32'(dout0), 32'h6);

        sel = 3'd5;
        idle();
        chk("sel_oob", 32'(dout0), 32'hFF);

        // Reset in the middle of activity
        sel = 3'd0;
        drv(1, 3, -3, 0, 0, 2'b00);
        rst = 1'b1;
        drv(1, 3, -3, 1, 0, 2'b00);
        chk("rst_mid_dout", 32'(dout0), 32'h0);
        chk("rst_mid_moved", 32'(mv[0]), 32'h0);
        chk("rst_mid_dir", 32'(dr[0]), 32'h0);
        rst = 1'b0;
        drv(0, 0, 0, 1, 0, 2'b00);
        idle();
        chk("rst_snap", 32'(dout0), 32'h0);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            int d0, d1;
            d0 = ($urandom_range(0, 3) == 0) ? 0 : $signed(8'($urandom));
            d1 = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 20)) - 10;
            sel = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 99) == 0);
            drv($urandom_range(0, 1) == 1, d0, d1, $urandom_range(0, 9) == 0,
                $urandom_range(0, 19) == 0, 2'($urandom));
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
